led_pattern_gen: RTL and testbench

Parametrised LED pattern generator driving the board LED bank: a free-running prescaler produces a periodic advance tick, and on each advance the LED register steps to the next pattern in one of four runtime-selectable modes: rotate right, rotate left, bounce, or true Fibonacci LFSR. It extends the single-mode 8-LED one-second rotator with configurable width and period, mode switching, pause/single-step control, and LFSR lock-up recovery. It sits directly between the board clock/reset and the LED pins.

---
 rtl/led_pattern_pkg.sv | 26 ++
 rtl/led_pattern_gen_tick_prescaler.sv | 55 +++++
 rtl/led_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// -----------------------------------------------------------------------------
// led_pattern_pkg
// Shared types for the LED pattern generator: the runtime pattern mode, the
// bounce direction, and a parity helper used for the LFSR feedback bit.
// -----------------------------------------------------------------------------
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ROR    = 2'd0,
        MODE_ROL    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_LFSR   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Even parity of the tapped bits; callers zero-extend narrower vectors
    // to 32 bits, which does not change the parity.
    function automatic logic lfsr_fb(input logic [31:0] value, input logic [31:0] taps);
        return ^(value & taps);
    endfunction

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running modulo-TICK_DIV counter producing the advance period.
//   clk     : system clock (rising edge)
//   reset_n : asynchronous active-low reset, counter returns to 0
//   hold    : freeze the counter at its current value
//   clear   : synchronous restart to 0 (wins over hold)
//   wrap    : combinational, high while the counter sits at TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic hold,
    input  logic clear,
    output logic wrap
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_MAX);
    assign wrap   = w_wrap;

    // Next counter value: clear beats hold, hold keeps a wrap pending.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clear) begin
            w_cnt_nxt = CNT_ZERO;
        end else if (hold) begin
            w_cnt_nxt = r_cnt;
        end else if (w_wrap) begin
            w_cnt_nxt = CNT_ZERO;
        end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= CNT_ZERO;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
// LED bank pattern generator. A prescaler produces one advance every TICK_DIV
// cycles; each advance steps the LED register in the selected mode
// (rotate right, rotate left, one-hot bounce, Fibonacci LFSR).
//   clk       : system clock (rising edge)
//   reset_n   : asynchronous active-low reset
//   mode      : requested mode, latched on mode_load
//   mode_load : one-cycle strobe, latch mode and restart the pattern
//   pause     : level, freezes prescaler and pattern
//   step      : one-cycle strobe, single advance while paused
//   led       : pattern register (WIDTH bits)
//   tick      : registered pulse, high the first cycle a new pattern shows
// -----------------------------------------------------------------------------
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               TICK_DIV = 100_000_000,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(1'b1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic             mode_load,
    input  logic             pause,
    input  logic             step,
    output logic [WIDTH-1:0] led,
    output logic             tick
);

    localparam logic [WIDTH-1:0] LED_ONE  = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0] LED_ZERO = WIDTH'(1'b0);

    mode_t            r_mode;
    dir_t             r_dir;
    logic [WIDTH-1:0] r_led;
    logic             r_tick;

    logic             w_wrap;
    logic             w_adv;
    logic             w_fb;
    mode_t            w_req_mode;
    logic [WIDTH-1:0] w_pat_led;
    dir_t             w_pat_dir;
    mode_t            w_mode_nxt;
    dir_t             w_dir_nxt;
    logic [WIDTH-1:0] w_led_nxt;
    logic             w_tick_nxt;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .hold    (pause),
        .clear   (mode_load),
        .wrap    (w_wrap)
    );

    // A step only counts while paused; a free-running wrap only while not.
    assign w_adv      = (w_wrap & ~pause) | (step & pause);
    assign w_fb       = lfsr_fb(32'(r_led), 32'(TAPS));
    assign w_req_mode = mode_t'(mode);

    // Pattern next-state for one advance in the current mode.
    always_comb begin
        w_pat_led = r_led;
        w_pat_dir = r_dir;
        case (r_mode)
            MODE_ROR: begin
                w_pat_led = {r_led[0], r_led[WIDTH-1:1]};
            end
            MODE_ROL: begin
                w_pat_led = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
            end
            MODE_BOUNCE: begin
                // Turn around at the end LED so the end is lit only once.
                if (r_dir == DIR_UP) begin
                    if (r_led[WIDTH-1]) begin
                        w_pat_led = r_led >> 1'b1;
                        w_pat_dir = DIR_DOWN;
                    end else begin
                        w_pat_led = r_led << 1'b1;
                    end
                end else begin
                    if (r_led[0]) begin
                        w_pat_led = r_led << 1'b1;
                        w_pat_dir = DIR_UP;
                    end else begin
                        w_pat_led = r_led >> 1'b1;
                    end
                end
            end
            MODE_LFSR: begin
                // All-zero is the LFSR lock-up state; reseed out of it.
                if (r_led == LED_ZERO) begin
                    w_pat_led = SEED;
                end else begin
                    w_pat_led = {r_led[WIDTH-2:0], w_fb};
                end
            end
            default: begin
                w_pat_led = r_led;
            end
        endcase
    end

    // Register next-state: mode_load beats advance beats hold.
    always_comb begin
        w_mode_nxt = r_mode;
        w_dir_nxt  = r_dir;
        w_led_nxt  = r_led;
        w_tick_nxt = 1'b0;
        if (mode_load) begin
            w_mode_nxt = w_req_mode;
            w_dir_nxt  = DIR_UP;
            w_led_nxt  = (w_req_mode == MODE_LFSR) ? SEED : LED_ONE;
            w_tick_nxt = 1'b0;
        end else if (w_adv) begin
            w_led_nxt  = w_pat_led;
            w_dir_nxt  = w_pat_dir;
            w_tick_nxt = 1'b1;
        end else begin
            w_tick_nxt = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= MODE_ROR;
            r_dir  <= DIR_UP;
            r_led  <= LED_ONE;
            r_tick <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
            r_dir  <= w_dir_nxt;
            r_led  <= w_led_nxt;
            r_tick <= w_tick_nxt;
        end
    end

    assign led  = r_led;
    assign tick = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
// Directed bench for led_pattern_gen at WIDTH=8, TICK_DIV=4. A second instance
// with no feedback taps and SEED=8'h5A drains to all-zero so the LFSR lock-up
// reseed can be observed through the ports.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

    logic       clk;
    logic       reset_n;
    logic [1:0] mode;
    logic       mode_load;
    logic       pause;
    logic       step;
    logic [7:0] led;
    logic       tick;
    logic [7:0] led_lk;
    logic       tick_lk;

    int n_checks;
    int n_errors;

    logic [7:0] lfsr_exp;
    logic       seen [0:255];

    led_pattern_gen #(
        .WIDTH    (8),
        .TICK_DIV (4),
        .TAPS     (8'hB8),
        .SEED     (8'h01)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .mode_load (mode_load),
        .pause     (pause),
        .step      (step),
        .led       (led),
        .tick      (tick)
    );

    led_pattern_gen #(
        .WIDTH    (8),
        .TICK_DIV (4),
        .TAPS     (8'h00),
        .SEED     (8'h5A)
    ) u_dut_lk (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .mode_load (mode_load),
        .pause     (pause),
        .step      (step),
        .led       (led_lk),
        .tick      (tick_lk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    // Four edges from cnt=0: three quiet cycles, then the advance.
    task automatic expect_adv(input logic [7:0] prev, input logic [7:0] nxt);
        for (int i = 1; i <= 4; i++) begin
            edge_sample();
            step = 1'b0;
            if (i < 4) begin
                check_eq("adv_hold_led", 32'(led), 32'(prev));
                check_eq("adv_hold_tick", 32'(tick), 32'd0);
            end else begin
                check_eq("adv_led", 32'(led), 32'(nxt));
                check_eq("adv_tick", 32'(tick), 32'd1);
            end
        end
    endtask

    task automatic do_load(input logic [1:0] m);
        mode      = m;
        mode_load = 1'b1;
        edge_sample();
        mode_load = 1'b0;
    endtask

    logic [7:0] ror_tab    [0:2];
    logic [7:0] bounce_tab [0:14];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        mode      = 2'd0;
        mode_load = 1'b0;
        pause     = 1'b0;
        step      = 1'b0;
        ror_tab    = '{8'h80, 8'h40, 8'h20};
        bounce_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                       8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        // Reset state.
        repeat (3) edge_sample();
        check_eq("rst_led", 32'(led), 32'h01);
        check_eq("rst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ROR: advances at edges 4, 8, 12.
        for (int k = 1; k <= 12; k++) begin
            edge_sample();
            if (k % 4 == 0) begin
                check_eq("ror_led", 32'(led), 32'(ror_tab[k/4 - 1]));
                check_eq("ror_tick", 32'(tick), 32'd1);
            end else begin
                check_eq("ror_tick_low", 32'(tick), 32'd0);
            end
        end
        check_eq("ror_final", 32'(led), 32'h20);

        // ROL.
        do_load(2'd1);
        check_eq("rol_load_led", 32'(led), 32'h01);
        check_eq("rol_load_tick", 32'(tick), 32'd0);
        expect_adv(8'h01, 8'h02);
        expect_adv(8'h02, 8'h04);

        // BOUNCE round trip and turn-around.
        do_load(2'd2);
        check_eq("bnc_load_led", 32'(led), 32'h01);
        for (int i = 0; i < 15; i++) begin
            expect_adv(i == 0 ? 8'h01 : bounce_tab[i-1], bounce_tab[i]);
        end

        // Pause: nothing moves for 20 cycles.
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            edge_sample();
            check_eq("pause_led", 32'(led), 32'h02);
            check_eq("pause_tick", 32'(tick), 32'd0);
        end
        // Three isolated step strobes.
        step = 1'b1; edge_sample(); step = 1'b0;
        check_eq("step1_led", 32'(led), 32'h04);
        check_eq("step1_tick", 32'(tick), 32'd1);
        edge_sample();
        check_eq("step1_tick_off", 32'(tick), 32'd0);
        step = 1'b1; edge_sample(); step = 1'b0;
        check_eq("step2_led", 32'(led), 32'h08);
        check_eq("step2_tick", 32'(tick), 32'd1);
        edge_sample();
        check_eq("step2_tick_off", 32'(tick), 32'd0);
        step = 1'b1; edge_sample(); step = 1'b0;
        check_eq("step3_led", 32'(led), 32'h10);
        check_eq("step3_tick", 32'(tick), 32'd1);
        edge_sample();
        check_eq("step3_tick_off", 32'(tick), 32'd0);
        // Back-to-back steps advance once per cycle.
        step = 1'b1;
        edge_sample();
        check_eq("b2b_led1", 32'(led), 32'h20);
        check_eq("b2b_tick1", 32'(tick), 32'd1);
        edge_sample();
        step = 1'b0;
        check_eq("b2b_led2", 32'(led), 32'h40);
        check_eq("b2b_tick2", 32'(tick), 32'd1);

        // Step with pause low is ignored; the held count resumes from 0.
        pause = 1'b0;
        step  = 1'b1;
        expect_adv(8'h40, 8'h80);

        // mode_load on the wrap cycle wins, next advance 4 edges later.
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            check_eq("pre_coll_led", 32'(led), 32'h80);
        end
        do_load(2'd0);
        check_eq("coll_led", 32'(led), 32'h01);
        check_eq("coll_tick", 32'(tick), 32'd0);
        expect_adv(8'h01, 8'h80);

        // pause rising on the wrap cycle: no advance, fires on release.
        repeat (3) edge_sample();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            check_eq("pwrap_led", 32'(led), 32'h80);
            check_eq("pwrap_tick", 32'(tick), 32'd0);
        end
        pause = 1'b0;
        edge_sample();
        check_eq("pwrap_rel_led", 32'(led), 32'h40);
        check_eq("pwrap_rel_tick", 32'(tick), 32'd1);
        expect_adv(8'h40, 8'h20);

        // LFSR: full 255-state period via back-to-back steps.
        pause = 1'b1;
        do_load(2'd3);
        check_eq("lfsr_load_led", 32'(led), 32'h01);
        check_eq("lfsr_load_tick", 32'(tick), 32'd0);
        check_eq("lk_load_led", 32'(led_lk), 32'h5A);
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[1] = 1'b1;
        lfsr_exp = 8'h01;
        step = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            edge_sample();
            lfsr_exp = {lfsr_exp[6:0], ^(lfsr_exp & 8'hB8)};
            check_eq("lfsr_led", 32'(led), 32'(lfsr_exp));
            if (k == 1) check_eq("lfsr_first", 32'(led), 32'h02);
            if (k < 255) begin
                check_eq("lfsr_unique", 32'(seen[led]), 32'd0);
                seen[led] = 1'b1;
            end
            if (k == 7) check_eq("lk_zero", 32'(led_lk), 32'h00);
            if (k == 8) begin
                check_eq("lk_reseed", 32'(led_lk), 32'h5A);
                check_eq("lk_tick", 32'(tick_lk), 32'd1);
            end
        end
        step = 1'b0;
        check_eq("lfsr_period", 32'(led), 32'h01);

        // Asynchronous reset mid-period.
        pause = 1'b0;
        do_load(2'd1);
        expect_adv(8'h01, 8'h02);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_led", 32'(led), 32'h01);
        check_eq("arst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        // Mode is back to ROR after reset.
        expect_adv(8'h01, 8'h80);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
